// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports and the shared memory port around mem_port_arbiter.
// The arbiter takes the master view because it drives the memory port; the CPU/bus side takes the slave view.
interface mem_port_arbiter_if;
    logic        r0_req;
    logic        r0_ready;
    logic [31:0] r0_addr;
    logic [3:0]  r0_byte_enable;
    logic        r0_write;
    logic [31:0] r0_write_data;
    logic [31:0] r0_read_data;
    logic        r0_read_data_valid;

    logic        r1_req;
    logic        r1_ready;
    logic [31:0] r1_addr;
    logic [3:0]  r1_byte_enable;
    logic        r1_write;
    logic [31:0] r1_write_data;
    logic [31:0] r1_read_data;
    logic        r1_read_data_valid;

    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_enable;
    logic        mem_read_req;
    logic        mem_write_req;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;

    modport master (
        input  r0_req, r0_addr, r0_byte_enable, r0_write, r0_write_data,
        output r0_ready, r0_read_data, r0_read_data_valid,
        input  r1_req, r1_addr, r1_byte_enable, r1_write, r1_write_data,
        output r1_ready, r1_read_data, r1_read_data_valid,
        input  mem_ready, mem_read_data, mem_read_data_valid,
        output mem_addr, mem_byte_enable, mem_read_req, mem_write_req, mem_write_data
    );

    modport slave (
        output r0_req, r0_addr, r0_byte_enable, r0_write, r0_write_data,
        input  r0_ready, r0_read_data, r0_read_data_valid,
        output r1_req, r1_addr, r1_byte_enable, r1_write, r1_write_data,
        input  r1_ready, r1_read_data, r1_read_data_valid,
        output mem_ready, mem_read_data, mem_read_data_valid,
        input  mem_addr, mem_byte_enable, mem_read_req, mem_write_req, mem_write_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (r0 = fetch, r1 = load/store) for one in-order memory port, with a read tag FIFO.
// MEM_PORT_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration; otherwise r0 has fixed priority.
module mem_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    mem_port_arbiter_if.master                   bus,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 idle
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             tag_mem [MAX_OUTSTANDING];

    logic grant0, grant1, any_grant, sel_write;
    logic fifo_full, fifo_empty, push, pop, head_tag;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    logic prio;
    logic accept;

    always_comb begin
        grant0 = bus.r0_req && (!bus.r1_req || !prio);
        grant1 = bus.r1_req && (!bus.r0_req ||  prio);
    end

    assign accept = (bus.r0_req && bus.r0_ready) || (bus.r1_req && bus.r1_ready);

    // prio names the requester that wins the next conflict: the one not served last
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            prio <= 1'b0;
        else if (accept)
            prio <= grant0;
    end
`else
    always_comb begin
        grant0 = bus.r0_req;
        grant1 = bus.r1_req && !bus.r0_req;
    end
`endif

    // Full is taken from the registered count only, so a same-cycle pop never frees a slot early
    assign fifo_full  = (count == CNT_MAX);
    assign fifo_empty = (count == '0);
    assign any_grant  = grant0 || grant1;
    assign sel_write  = grant0 ? bus.r0_write : bus.r1_write;

    always_comb begin
        bus.r0_ready      = reset_n && bus.mem_ready && grant0 && (bus.r0_write || !fifo_full);
        bus.r1_ready      = reset_n && bus.mem_ready && grant1 && (bus.r1_write || !fifo_full);
        bus.mem_read_req  = reset_n && any_grant && !sel_write && !fifo_full;
        bus.mem_write_req = reset_n && any_grant && sel_write;
        bus.mem_addr        = '0;
        bus.mem_byte_enable = '0;
        bus.mem_write_data  = '0;
        if (grant0) begin
            bus.mem_addr        = bus.r0_addr;
            bus.mem_byte_enable = bus.r0_byte_enable;
            bus.mem_write_data  = bus.r0_write_data;
        end else if (grant1) begin
            bus.mem_addr        = bus.r1_addr;
            bus.mem_byte_enable = bus.r1_byte_enable;
            bus.mem_write_data  = bus.r1_write_data;
        end
    end

    assign push     = bus.mem_read_req && bus.mem_ready;
    assign pop      = reset_n && bus.mem_read_data_valid && !fifo_empty;
    assign head_tag = tag_mem[rd_ptr];

    // Returned data goes to whoever owns the oldest read; data with no owner is dropped
    always_comb begin
        bus.r0_read_data       = bus.mem_read_data;
        bus.r1_read_data       = bus.mem_read_data;
        bus.r0_read_data_valid = pop && !head_tag;
        bus.r1_read_data_valid = pop &&  head_tag;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant1;
    end

    assign outstanding = count;
    assign idle        = (count == '0) && !bus.r0_req && !bus.r1_req;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: request muxing, tag FIFO routing, full/write bypass, stalls, async reset.
module tb_mem_port_arbiter;
    logic       clk;
    logic       reset_n;
    logic [2:0] outstanding;
    logic       idle;
    int         tests;
    int         fails;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.master),
        .outstanding (outstanding),
        .idle        (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.r0_req = 0; bus.r0_addr = 0; bus.r0_byte_enable = 0; bus.r0_write = 0; bus.r0_write_data = 0;
        bus.r1_req = 0; bus.r1_addr = 0; bus.r1_byte_enable = 0; bus.r1_write = 0; bus.r1_write_data = 0;
        bus.mem_read_data = 0; bus.mem_read_data_valid = 0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        bus.mem_ready = 1;
        reset_n = 0;
        bus.r0_req = 1;
        #1;
        check("rst_r0_ready", 32'(bus.r0_ready), 0);
        check("rst_mem_read_req", 32'(bus.mem_read_req), 0);
        cycle();
        cycle();
        bus.r0_req = 0;
        #1;
        check("rst_outstanding", 32'(outstanding), 0);
        check("rst_idle", 32'(idle), 1);
        check("rst_mem_addr", bus.mem_addr, 0);
        reset_n = 1;
        cycle();

        // r0 read at 0x100, data three cycles later
        bus.r0_req = 1; bus.r0_addr = 32'h100; bus.r0_byte_enable = 4'hF; bus.r0_write = 0;
        #1;
        check("t1_mem_addr", bus.mem_addr, 32'h100);
        check("t1_mem_be", 32'(bus.mem_byte_enable), 32'hF);
        check("t1_mem_read_req", 32'(bus.mem_read_req), 1);
        check("t1_r0_ready", 32'(bus.r0_ready), 1);
        check("t1_mem_write_req", 32'(bus.mem_write_req), 0);
        cycle();
        bus.r0_req = 0;
        #1;
        check("t1_outstanding", 32'(outstanding), 1);
        cycle();
        cycle();
        bus.mem_read_data = 32'hDEADBEEF; bus.mem_read_data_valid = 1;
        #1;
        check("t1_r0_valid", 32'(bus.r0_read_data_valid), 1);
        check("t1_r0_data", bus.r0_read_data, 32'hDEADBEEF);
        check("t1_r1_valid", 32'(bus.r1_read_data_valid), 0);
        cycle();
        bus.mem_read_data_valid = 0;
        #1;
        check("t1_drained", 32'(outstanding), 0);
        check("t1_idle", 32'(idle), 1);

        // Fill the tag FIFO with four r0 reads
        bus.r0_req = 1; bus.r0_addr = 32'h10; bus.r0_byte_enable = 4'hF; bus.r0_write = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("t3_full_count", 32'(outstanding), 4);
        #1;
        check("t3_full_r0_ready", 32'(bus.r0_ready), 0);
        check("t3_full_read_req", 32'(bus.mem_read_req), 0);
        bus.r0_req = 0;
        bus.r1_req = 1; bus.r1_addr = 32'h20; bus.r1_byte_enable = 4'hF; bus.r1_write = 0;
        #1;
        check("t3_full_r1_ready", 32'(bus.r1_ready), 0);

        // Write while full still goes through
        bus.r1_addr = 32'h200; bus.r1_write = 1; bus.r1_write_data = 32'h12345678; bus.r1_byte_enable = 4'h3;
        #1;
        check("t4_r1_ready", 32'(bus.r1_ready), 1);
        check("t4_write_req", 32'(bus.mem_write_req), 1);
        check("t4_read_req", 32'(bus.mem_read_req), 0);
        check("t4_write_data", bus.mem_write_data, 32'h12345678);
        check("t4_addr", bus.mem_addr, 32'h200);
        check("t4_be", 32'(bus.mem_byte_enable), 32'h3);
        cycle();
        bus.r1_req = 0; bus.r1_write = 0;
        #1;
        check("t4_count_kept", 32'(outstanding), 4);

        // One return frees a slot for the next cycle; then push+pop together
        bus.mem_read_data = 32'h11; bus.mem_read_data_valid = 1;
        bus.r0_req = 1;
        #1;
        check("t3_pop_r0_valid", 32'(bus.r0_read_data_valid), 1);
        check("t3_no_bypass", 32'(bus.r0_ready), 0);
        cycle();
        check("t3_after_pop", 32'(outstanding), 3);
        check("t3_ready_again", 32'(bus.r0_ready), 1);
        cycle();
        check("t3_push_pop", 32'(outstanding), 3);
        bus.r0_req = 0;
        cycle();
        cycle();
        cycle();
        bus.mem_read_data_valid = 0;
        #1;
        check("t3_drained", 32'(outstanding), 0);

        // Memory stall with r1 requesting
        bus.mem_ready = 0;
        bus.r1_req = 1; bus.r1_addr = 32'h300; bus.r1_byte_enable = 4'hF; bus.r1_write = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_stall_ready", 32'(bus.r1_ready), 0);
            cycle();
        end
        check("t5_no_push", 32'(outstanding), 0);
        bus.mem_ready = 1;
        #1;
        check("t5_accept", 32'(bus.r1_ready), 1);
        cycle();
        bus.r1_req = 0;
        check("t5_count", 32'(outstanding), 1);
        bus.mem_read_data = 32'h55AA55AA; bus.mem_read_data_valid = 1;
        #1;
        check("t5_r1_valid", 32'(bus.r1_read_data_valid), 1);
        check("t5_r0_valid", 32'(bus.r0_read_data_valid), 0);
        check("t5_r1_data", bus.r1_read_data, 32'h55AA55AA);
        cycle();
        bus.mem_read_data_valid = 0;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        // Last served was r1, so conflicts alternate starting with r0
        bus.r0_req = 1; bus.r0_addr = 32'h1000; bus.r0_write = 0;
        bus.r1_req = 1; bus.r1_addr = 32'h2000; bus.r1_write = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_r0_grant", 32'(bus.r0_ready), (i % 2 == 0) ? 1 : 0);
            check("t2_r1_grant", 32'(bus.r1_ready), (i % 2 == 1) ? 1 : 0);
            check("t2_addr", bus.mem_addr, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            cycle();
        end
        bus.r0_req = 0; bus.r1_req = 0;
        check("t2_count", 32'(outstanding), 4);
        for (int i = 0; i < 4; i++) begin
            bus.mem_read_data = 32'hA0 + 32'(i); bus.mem_read_data_valid = 1;
            #1;
            check("t2_route_r0", 32'(bus.r0_read_data_valid), (i % 2 == 0) ? 1 : 0);
            check("t2_route_r1", 32'(bus.r1_read_data_valid), (i % 2 == 1) ? 1 : 0);
            cycle();
        end
        bus.mem_read_data_valid = 0;
`else
        // Fixed priority: r0 wins every conflict
        bus.r0_req = 1; bus.r0_addr = 32'h1000; bus.r0_write = 0;
        bus.r1_req = 1; bus.r1_addr = 32'h2000; bus.r1_write = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("fx_r0_grant", 32'(bus.r0_ready), 1);
            check("fx_r1_grant", 32'(bus.r1_ready), 0);
            check("fx_addr", bus.mem_addr, 32'h1000);
            cycle();
        end
        bus.r0_req = 0; bus.r1_req = 0;
        check("fx_count", 32'(outstanding), 3);
        for (int i = 0; i < 3; i++) begin
            bus.mem_read_data = 32'hB0 + 32'(i); bus.mem_read_data_valid = 1;
            #1;
            check("fx_route_r0", 32'(bus.r0_read_data_valid), 1);
            cycle();
        end
        bus.mem_read_data_valid = 0;
`endif
        #1;
        check("pre6_empty", 32'(outstanding), 0);

        // Two reads in flight, then reset mid-cycle
        bus.r0_req = 1; bus.r0_addr = 32'h400; bus.r0_write = 0;
        cycle();
        cycle();
        bus.r0_req = 0;
        check("t6_two_out", 32'(outstanding), 2);
        #2;
        reset_n = 0;
        bus.r0_req = 1;
        bus.mem_read_data_valid = 1;
        #1;
        check("t6_rst_count", 32'(outstanding), 0);
        check("t6_rst_ready", 32'(bus.r0_ready), 0);
        check("t6_rst_read_req", 32'(bus.mem_read_req), 0);
        check("t6_rst_valid", 32'(bus.r0_read_data_valid), 0);
        bus.r0_write = 1;
        #1;
        check("t6_rst_write_req", 32'(bus.mem_write_req), 0);
        bus.r0_req = 0; bus.r0_write = 0; bus.mem_read_data_valid = 0;
        cycle();
        reset_n = 1;
        cycle();
        for (int i = 0; i < 2; i++) begin
            bus.mem_read_data = 32'hC0; bus.mem_read_data_valid = 1;
            #1;
            check("t6_stray_r0", 32'(bus.r0_read_data_valid), 0);
            check("t6_stray_r1", 32'(bus.r1_read_data_valid), 0);
            cycle();
        end
        bus.mem_read_data_valid = 0;
        #1;
        check("t6_idle", 32'(idle), 1);
        check("t6_count", 32'(outstanding), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
